// File: rtl/fxu_reservation_station_if.sv
// Dispatch, ROB-snoop and issue signals of one FXU reservation station.
// The slave modport is the station's view; master is the dispatcher/FXU side.
interface fxu_reservation_station_if;
   logic         flush;
   logic         in_instr_valid;
   logic [3:0]   in_rob_idx;
   logic [3:0]   in_opcode;
   logic [7:0]   in_i;
   logic         in_a_valid;
   logic         in_b_valid;
   logic [15:0]  in_a_value;
   logic [15:0]  in_b_value;
   logic [3:0]   in_a_owner;
   logic [3:0]   in_b_owner;
   logic [15:0]  rob_output_valid_flat;
   logic [255:0] rob_output_values_flat;
   logic         fxu_ready;
   logic         full;
   logic         out_valid;
   logic [3:0]   out_rob_idx;
   logic [3:0]   out_opcode;
   logic [7:0]   out_i;
   logic [15:0]  out_a_value;
   logic [15:0]  out_b_value;
   logic [3:0]   dbg_count;

   // Handshake: an instruction moves from the issue register to the FXU on any
   // posedge where out_valid & fxu_ready; out_* stay stable while out_valid & ~fxu_ready.
   modport slave (
      input  flush, in_instr_valid, in_rob_idx, in_opcode, in_i,
             in_a_valid, in_b_valid, in_a_value, in_b_value, in_a_owner, in_b_owner,
             rob_output_valid_flat, rob_output_values_flat, fxu_ready,
      output full, out_valid, out_rob_idx, out_opcode, out_i,
             out_a_value, out_b_value, dbg_count
   );

   modport master (
      output flush, in_instr_valid, in_rob_idx, in_opcode, in_i,
             in_a_valid, in_b_valid, in_a_value, in_b_value, in_a_owner, in_b_owner,
             rob_output_valid_flat, rob_output_values_flat, fxu_ready,
      input  full, out_valid, out_rob_idx, out_opcode, out_i,
             out_a_value, out_b_value, dbg_count
   );
endinterface

// File: rtl/fxu_reservation_station.sv
// FXU reservation station: collapsing queue that snoops ROB results for missing
// operands and issues the oldest fully-ready entry into a single issue register.
module fxu_reservation_station #(
   parameter int DEPTH = 4
) (
   input logic                      clk,
   input logic                      rst,
   fxu_reservation_station_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);

   typedef struct packed {
      logic        valid;
      logic [3:0]  rob_idx;
      logic [3:0]  opcode;
      logic [7:0]  imm;
      logic        a_rdy;
      logic [15:0] a_value;
      logic [3:0]  a_owner;
      logic        b_rdy;
      logic [15:0] b_value;
      logic [3:0]  b_owner;
   } slot_t;

   slot_t         r_slot [DEPTH];
   logic [CW-1:0] r_count;
   logic          r_full;
   logic          r_out_valid;
   logic [3:0]    r_out_rob_idx;
   logic [3:0]    r_out_opcode;
   logic [7:0]    r_out_i;
   logic [15:0]   r_out_a_value;
   logic [15:0]   r_out_b_value;

   logic [15:0]   w_rob_vld;
   logic [15:0]   w_rob_val [16];
   slot_t         w_woken [DEPTH];
   slot_t         w_up [DEPTH];
   slot_t         w_next [DEPTH];
   slot_t         w_new;
   logic          w_cand_found;
   logic [IW-1:0] w_cand_idx;
   logic          w_issue;
   logic          w_alloc;
   logic [CW-1:0] w_alloc_pos;
   logic [CW-1:0] w_count_nxt;

   // ROB entry k lives at the high end of the flat buses (entry 0 = MSBs).
   always_comb begin
      for (int k = 0; k < 16; k++) begin
         w_rob_vld[k] = bus.rob_output_valid_flat[15-k];
         w_rob_val[k] = bus.rob_output_values_flat[16*(15-k) +: 16];
      end
   end

   always_comb begin
      for (int s = 0; s < DEPTH; s++) begin
         w_woken[s] = r_slot[s];
         if (r_slot[s].valid && !r_slot[s].a_rdy && w_rob_vld[r_slot[s].a_owner]) begin
            w_woken[s].a_rdy   = 1'b1;
            w_woken[s].a_value = w_rob_val[r_slot[s].a_owner];
         end
         if (r_slot[s].valid && !r_slot[s].b_rdy && w_rob_vld[r_slot[s].b_owner]) begin
            w_woken[s].b_rdy   = 1'b1;
            w_woken[s].b_value = w_rob_val[r_slot[s].b_owner];
         end
      end
   end

   always_comb begin
      w_new.valid   = 1'b1;
      w_new.rob_idx = bus.in_rob_idx;
      w_new.opcode  = bus.in_opcode;
      w_new.imm     = bus.in_i;
      w_new.a_owner = bus.in_a_owner;
      w_new.b_owner = bus.in_b_owner;
      w_new.a_rdy   = bus.in_a_valid | w_rob_vld[bus.in_a_owner];
      w_new.a_value = bus.in_a_valid ? bus.in_a_value : w_rob_val[bus.in_a_owner];
      w_new.b_rdy   = bus.in_b_valid | w_rob_vld[bus.in_b_owner];
      w_new.b_value = bus.in_b_valid ? bus.in_b_value : w_rob_val[bus.in_b_owner];
   end

   // Selection looks only at registered ready bits, so a wakeup counts next cycle.
   always_comb begin
      w_cand_found = 1'b0;
      w_cand_idx   = '0;
      for (int s = DEPTH - 1; s >= 0; s--) begin
         if (r_slot[s].valid && r_slot[s].a_rdy && r_slot[s].b_rdy) begin
            w_cand_found = 1'b1;
            w_cand_idx   = IW'(s);
         end
      end
   end

   assign w_issue     = w_cand_found & (~r_out_valid | bus.fxu_ready);
   assign w_alloc     = bus.in_instr_valid & ~r_full;
   assign w_alloc_pos = w_issue ? (r_count - CW'(1)) : r_count;
   assign w_count_nxt = r_count + CW'(w_alloc) - CW'(w_issue);

   always_comb begin
      for (int s = 0; s < DEPTH - 1; s++) begin
         w_up[s] = w_woken[s+1];
      end
      w_up[DEPTH-1] = '0;
      for (int s = 0; s < DEPTH; s++) begin
         w_next[s] = w_woken[s];
         if (w_issue && s >= int'(w_cand_idx)) begin
            w_next[s] = w_up[s];
         end
         if (w_alloc && int'(w_alloc_pos) == s) begin
            w_next[s] = w_new;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         for (int s = 0; s < DEPTH; s++) begin
            r_slot[s] <= '0;
         end
         r_count       <= '0;
         r_full        <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_rob_idx <= '0;
         r_out_opcode  <= '0;
         r_out_i       <= '0;
         r_out_a_value <= '0;
         r_out_b_value <= '0;
      end else begin
         for (int s = 0; s < DEPTH; s++) begin
            r_slot[s] <= w_next[s];
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(DEPTH));
         if (w_issue) begin
            r_out_valid   <= 1'b1;
            r_out_rob_idx <= r_slot[w_cand_idx].rob_idx;
            r_out_opcode  <= r_slot[w_cand_idx].opcode;
            r_out_i       <= r_slot[w_cand_idx].imm;
            r_out_a_value <= r_slot[w_cand_idx].a_value;
            r_out_b_value <= r_slot[w_cand_idx].b_value;
         end else if (r_out_valid && bus.fxu_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.full        = r_full;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_rob_idx = r_out_rob_idx;
   assign bus.out_opcode  = r_out_opcode;
   assign bus.out_i       = r_out_i;
   assign bus.out_a_value = r_out_a_value;
   assign bus.out_b_value = r_out_b_value;
   assign bus.dbg_count   = 4'(r_count);
endmodule

// File: tb/tb_fxu_reservation_station.sv
// Directed bench for fxu_reservation_station (DEPTH = 4).
module tb_fxu_reservation_station;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   fxu_reservation_station_if rs_if();

   fxu_reservation_station #(.DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (rs_if)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      rs_if.in_instr_valid = 1'b0;
      rs_if.in_rob_idx     = '0;
      rs_if.in_opcode      = '0;
      rs_if.in_i           = '0;
      rs_if.in_a_valid     = 1'b0;
      rs_if.in_b_valid     = 1'b0;
      rs_if.in_a_value     = '0;
      rs_if.in_b_value     = '0;
      rs_if.in_a_owner     = '0;
      rs_if.in_b_owner     = '0;
   endtask

   task automatic rob_clear();
      rs_if.rob_output_valid_flat  = '0;
      rs_if.rob_output_values_flat = '0;
   endtask

   task automatic rob_post(input int k, input logic [15:0] val);
      rs_if.rob_output_valid_flat[15-k]              = 1'b1;
      rs_if.rob_output_values_flat[16*(15-k) +: 16] = val;
   endtask

   task automatic disp(input logic [3:0] rob, input logic [3:0] op, input logic [7:0] imm,
                       input logic av, input logic [15:0] aval, input logic [3:0] aown,
                       input logic bv, input logic [15:0] bval, input logic [3:0] bown);
      rs_if.in_instr_valid = 1'b1;
      rs_if.in_rob_idx     = rob;
      rs_if.in_opcode      = op;
      rs_if.in_i           = imm;
      rs_if.in_a_valid     = av;
      rs_if.in_a_value     = aval;
      rs_if.in_a_owner     = aown;
      rs_if.in_b_valid     = bv;
      rs_if.in_b_value     = bval;
      rs_if.in_b_owner     = bown;
   endtask

   task automatic disp_ready(input logic [3:0] rob, input logic [15:0] a, input logic [15:0] b);
      disp(rob, rob ^ 4'hA, {4'h5, rob}, 1'b1, a, 4'h0, 1'b1, b, 4'h0);
   endtask

   function automatic logic [48:0] act_out();
      return {rs_if.out_valid, rs_if.out_rob_idx, rs_if.out_opcode, rs_if.out_i,
              rs_if.out_a_value, rs_if.out_b_value};
   endfunction

   function automatic logic [48:0] exp_ready(input logic [3:0] rob, input logic [15:0] a,
                                             input logic [15:0] b);
      return {1'b1, rob, rob ^ 4'hA, 4'h5, rob, a, b};
   endfunction

   task automatic reset_dut();
      rst = 1'b1;
      rs_if.flush = 1'b0;
      rs_if.fxu_ready = 1'b0;
      clear_in();
      rob_clear();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      reset_dut();
      step();
      checks++;
      if (act_out() !== 49'd0) begin
         errors++;
         $display("FAIL reset_out actual=%h required=%h", act_out(), 49'd0);
      end
      checks++;
      if ({rs_if.full, rs_if.dbg_count} !== 5'd0) begin
         errors++;
         $display("FAIL reset_full_count actual=%h required=%h", {rs_if.full, rs_if.dbg_count}, 5'd0);
      end
   endtask

   task automatic test_back_to_back();
      logic [48:0] exp;
      reset_dut();
      rs_if.fxu_ready = 1'b1;
      for (int r = 1; r <= 4; r++) begin
         disp_ready(4'(r), 16'(r * 3), 16'(r * 5));
         step();
         if (r > 1) begin
            exp = exp_ready(4'(r - 1), 16'((r - 1) * 3), 16'((r - 1) * 5));
            checks++;
            if (act_out() !== exp) begin
               errors++;
               $display("FAIL b2b_issue_%0d actual=%h required=%h", r - 1, act_out(), exp);
            end
         end
         checks++;
         if (rs_if.full !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full_%0d actual=%b required=0", r, rs_if.full);
         end
      end
      clear_in();
      step();
      exp = exp_ready(4'd4, 16'd12, 16'd20);
      checks++;
      if (act_out() !== exp) begin
         errors++;
         $display("FAIL b2b_issue_4 actual=%h required=%h", act_out(), exp);
      end
      step();
      checks++;
      if (rs_if.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain actual=%b required=0", rs_if.out_valid);
      end
   endtask

   task automatic test_alloc_wakeup();
      logic [48:0] exp;
      reset_dut();
      rs_if.fxu_ready = 1'b1;
      rob_post(0, 16'h0F0F);
      rob_post(15, 16'hBEEF);
      disp(4'd7, 4'd3, 8'h42, 1'b0, 16'hFFFF, 4'd0, 1'b0, 16'hFFFF, 4'd15);
      step();
      clear_in();
      rob_clear();
      checks++;
      if (rs_if.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL allocwake_early actual=%b required=0", rs_if.out_valid);
      end
      step();
      exp = {1'b1, 4'd7, 4'd3, 8'h42, 16'h0F0F, 16'hBEEF};
      checks++;
      if (act_out() !== exp) begin
         errors++;
         $display("FAIL allocwake_issue actual=%h required=%h", act_out(), exp);
      end
   endtask

   task automatic test_wakeup();
      logic [48:0] exp;
      reset_dut();
      rs_if.fxu_ready = 1'b1;
      disp(4'd2, 4'd1, 8'h10, 1'b0, 16'h0000, 4'd9, 1'b1, 16'h0055, 4'd0);
      step();
      clear_in();
      step();
      step();
      step();
      checks++;
      if (rs_if.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL wakeup_waiting actual=%b required=0", rs_if.out_valid);
      end
      rob_post(9, 16'h00AB);
      step();
      rob_clear();
      checks++;
      if (rs_if.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL wakeup_latency actual=%b required=0", rs_if.out_valid);
      end
      step();
      exp = {1'b1, 4'd2, 4'd1, 8'h10, 16'h00AB, 16'h0055};
      checks++;
      if (act_out() !== exp) begin
         errors++;
         $display("FAIL wakeup_issue actual=%h required=%h", act_out(), exp);
      end
   endtask

   task automatic test_age_bypass();
      logic [48:0] exp;
      reset_dut();
      rs_if.fxu_ready = 1'b1;
      disp(4'd3, 4'd2, 8'h33, 1'b0, 16'h0000, 4'd7, 1'b1, 16'h0003, 4'd0);
      step();
      disp_ready(4'd4, 16'h0044, 16'h0045);
      step();
      clear_in();
      step();
      exp = exp_ready(4'd4, 16'h0044, 16'h0045);
      checks++;
      if (act_out() !== exp) begin
         errors++;
         $display("FAIL bypass_young actual=%h required=%h", act_out(), exp);
      end
      step();
      checks++;
      if (rs_if.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bypass_stall actual=%b required=0", rs_if.out_valid);
      end
      rob_post(7, 16'h1234);
      step();
      rob_clear();
      step();
      exp = {1'b1, 4'd3, 4'd2, 8'h33, 16'h1234, 16'h0003};
      checks++;
      if (act_out() !== exp) begin
         errors++;
         $display("FAIL bypass_old actual=%h required=%h", act_out(), exp);
      end
   endtask

   task automatic test_full_backpressure();
      logic [48:0] exp;
      reset_dut();
      for (int r = 1; r <= 5; r++) begin
         disp_ready(4'(r), 16'(r * 3), 16'(r * 5));
         step();
      end
      exp = exp_ready(4'd1, 16'd3, 16'd5);
      checks++;
      if ({act_out(), rs_if.full, rs_if.dbg_count} !== {exp, 1'b1, 4'd4}) begin
         errors++;
         $display("FAIL bp_filled actual=%h required=%h", {act_out(), rs_if.full, rs_if.dbg_count}, {exp, 1'b1, 4'd4});
      end
      disp_ready(4'd6, 16'h0066, 16'h0067);
      step();
      clear_in();
      checks++;
      if ({act_out(), rs_if.full, rs_if.dbg_count} !== {exp, 1'b1, 4'd4}) begin
         errors++;
         $display("FAIL bp_dropped actual=%h required=%h", {act_out(), rs_if.full, rs_if.dbg_count}, {exp, 1'b1, 4'd4});
      end
      rs_if.fxu_ready = 1'b1;
      step();
      exp = exp_ready(4'd2, 16'd6, 16'd10);
      checks++;
      if ({act_out(), rs_if.full, rs_if.dbg_count} !== {exp, 1'b0, 4'd3}) begin
         errors++;
         $display("FAIL bp_release actual=%h required=%h", {act_out(), rs_if.full, rs_if.dbg_count}, {exp, 1'b0, 4'd3});
      end
      for (int r = 3; r <= 5; r++) begin
         step();
         exp = exp_ready(4'(r), 16'(r * 3), 16'(r * 5));
         checks++;
         if (act_out() !== exp) begin
            errors++;
            $display("FAIL bp_drain_%0d actual=%h required=%h", r, act_out(), exp);
         end
      end
      step();
      checks++;
      if (rs_if.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_no_rob6 actual=%b required=0", rs_if.out_valid);
      end
   endtask

   task automatic test_flush();
      reset_dut();
      for (int r = 1; r <= 3; r++) begin
         disp_ready(4'(r), 16'(r), 16'(r));
         step();
      end
      clear_in();
      checks++;
      if ({rs_if.out_valid, rs_if.dbg_count} !== {1'b1, 4'd2}) begin
         errors++;
         $display("FAIL flush_setup actual=%h required=%h", {rs_if.out_valid, rs_if.dbg_count}, {1'b1, 4'd2});
      end
      rs_if.flush = 1'b1;
      disp_ready(4'd9, 16'h0009, 16'h0009);
      step();
      rs_if.flush = 1'b0;
      clear_in();
      checks++;
      if ({rs_if.out_valid, rs_if.full, rs_if.dbg_count} !== 6'd0) begin
         errors++;
         $display("FAIL flush_clear actual=%h required=%h", {rs_if.out_valid, rs_if.full, rs_if.dbg_count}, 6'd0);
      end
      rs_if.fxu_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         checks++;
         if (rs_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_issue_%0d actual=%b required=0", c, rs_if.out_valid);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      logic [48:0] exp;
      reset_dut();
      for (int r = 1; r <= 3; r++) begin
         disp_ready(4'(r), 16'(r), 16'(r));
         step();
      end
      clear_in();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({act_out(), rs_if.full, rs_if.dbg_count} !== 54'd0) begin
         errors++;
         $display("FAIL midreset_clear actual=%h required=%h", {act_out(), rs_if.full, rs_if.dbg_count}, 54'd0);
      end
      rs_if.fxu_ready = 1'b1;
      disp(4'd5, 4'd6, 8'h77, 1'b1, 16'd3, 4'd0, 1'b1, 16'd4, 4'd0);
      step();
      clear_in();
      checks++;
      if (rs_if.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_latency actual=%b required=0", rs_if.out_valid);
      end
      step();
      exp = {1'b1, 4'd5, 4'd6, 8'h77, 16'd3, 16'd4};
      checks++;
      if (act_out() !== exp) begin
         errors++;
         $display("FAIL midreset_issue actual=%h required=%h", act_out(), exp);
      end
   endtask

   initial begin
      rs_if.flush = 1'b0;
      rs_if.fxu_ready = 1'b0;
      clear_in();
      rob_clear();
      test_reset();
      test_back_to_back();
      test_alloc_wakeup();
      test_wakeup();
      test_age_bypass();
      test_full_backpressure();
      test_flush();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
